// File: rtl/pulse_sync_mc.sv
// Multi-channel fast->slow pulse synchroniser: per-channel pending counter feeding a
// toggle req/ack handshake from clka to clkb, one clkb pulse per accepted clka pulse.
module pulse_sync_mc #(
  parameter int  CH          = 4,
  parameter int  SYNC_STAGES = 2,
  parameter int  MAX_PEND    = 7,
  localparam int CNT_W       = $clog2(MAX_PEND + 1)
) (
  input  logic                clka,
  input  logic                clkb,
  input  logic                rst,
  input  logic [CH-1:0]       pulse_a,
  input  logic [CH-1:0]       ovf_clr_a,
  output logic [CH-1:0]       busy_a,
  output logic [CH*CNT_W-1:0] pend_a,
  output logic [CH-1:0]       ovf_a,
  output logic [CH-1:0]       pulse_b
);

  localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(MAX_PEND);
  localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

  // clka domain state
  logic [CH-1:0]                  r_req_tog;
  logic [CH-1:0][SYNC_STAGES-1:0] r_ack_sync;
  logic [CH-1:0][CNT_W-1:0]       r_pend;
  logic [CH-1:0]                  r_ovf;

  // clkb domain state
  logic [CH-1:0][SYNC_STAGES-1:0] r_req_sync;
  logic [CH-1:0]                  r_req_hist;
  logic [CH-1:0]                  r_pulse_b;

  logic [CH-1:0] w_busy;
  logic [CH-1:0] w_launch;
  logic [CH-1:0] w_drop;

  always_comb begin
    w_busy   = '0;
    w_launch = '0;
    w_drop   = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      w_busy[i]   = r_req_tog[i] ^ r_ack_sync[i][SYNC_STAGES-1];
      w_launch[i] = !w_busy[i] && (r_pend[i] != '0);
      w_drop[i]   = pulse_a[i] && !w_launch[i] && (r_pend[i] == PEND_MAX);
    end
  end

  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      r_req_tog  <= '0;
      r_ack_sync <= '0;
      r_pend     <= '0;
      r_ovf      <= '0;
    end else begin
      for (int unsigned i = 0; i < CH; i++) begin
        // ack is the last clkb synchroniser stage, re-synchronised into clka
        r_ack_sync[i] <= {r_ack_sync[i][SYNC_STAGES-2:0], r_req_sync[i][SYNC_STAGES-1]};
        if (w_launch[i])
          r_req_tog[i] <= ~r_req_tog[i];
        case ({w_launch[i], pulse_a[i]})
          2'b10:   r_pend[i] <= r_pend[i] - PEND_ONE;
          2'b01:   if (!w_drop[i]) r_pend[i] <= r_pend[i] + PEND_ONE;
          default: r_pend[i] <= r_pend[i];
        endcase
        if (w_drop[i])
          r_ovf[i] <= 1'b1;
        else if (ovf_clr_a[i])
          r_ovf[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clkb or negedge rst) begin
    if (!rst) begin
      r_req_sync <= '0;
      r_req_hist <= '0;
      r_pulse_b  <= '0;
    end else begin
      for (int unsigned i = 0; i < CH; i++) begin
        r_req_sync[i] <= {r_req_sync[i][SYNC_STAGES-2:0], r_req_tog[i]};
        r_req_hist[i] <= r_req_sync[i][SYNC_STAGES-1];
        r_pulse_b[i]  <= r_req_sync[i][SYNC_STAGES-1] ^ r_req_hist[i];
      end
    end
  end

  assign busy_a  = w_busy;
  assign pend_a  = r_pend;
  assign ovf_a   = r_ovf;
  assign pulse_b = r_pulse_b;

endmodule
